fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//  Per-sample controller for the FP16 FIR MAC datapath. On each sample strobe it
//  writes the new sample into the circular data memory, then walks all NTAPS
//  coefficient/data address pairs, driving MAC enable and accumulator clear.
//  After the MAC pipeline drains it pulses dout_valid. Yields to the coefficient
//  loader (cload) and flags overrun and abort conditions.
// PARAMETERS
//  NTAPS    65  number of filter taps (>=2)
//  CAW      7   coefficient address width, 2^CAW >= NTAPS
//  DAW      7   data-memory address width, 2^DAW >= NTAPS
//  MAC_LAT  3   cycles from last mac_en to accumulator result valid (>=1)
// PORTS
//  clk         in   1    fast processing clock
//  rst_n       in   1    asynchronous active-low reset
//  sample_stb  in   1    1-cycle pulse per input sample (clk domain, pre-synchronised)
//  cload       in   1    coefficient load in progress; loader owns coefficient memory
//  ovr_clr     in   1    clears overrun and abort_err
//  dwr_en      out  1    write enable, data memory (new sample)
//  dwr_addr    out  DAW  data memory write address (= wptr)
//  crd_addr    out  CAW  coefficient read address (= tap)
//  drd_addr    out  DAW  data read address (= wptr - tap mod 2^DAW)
//  mac_en      out  1    MAC operand valid this cycle
//  acc_clr     out  1    accumulator load (not add) this cycle; tap 0 only
//  dout_valid  out  1    1-cycle pulse: FIR result valid
//  busy        out  1    state != IDLE
//  overrun     out  1    sticky: sample dropped
//  abort_err   out  1    sticky: computation aborted by cload
// BEHAVIOUR
//  Reset: state=IDLE, wptr=0, tap=0, pending=0; all outputs 0, addresses 0.
//  States: IDLE -> WRITE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: sample_stb|pending with cload=0 -> WRITE, clear pending.
//        sample_stb with cload=1 -> pending=1, stay IDLE.
//        sample_stb while pending=1 -> overrun=1 (one sample held max).
//  WRITE (1 cycle): dwr_en=1, dwr_addr=wptr; tap<=0; -> RUN.
//  RUN (NTAPS cycles): mac_en=1, crd_addr=tap, drd_addr=wptr-tap mod 2^DAW;
//        acc_clr=1 only when tap==0; tap++; at tap==NTAPS-1 -> DRAIN.
//  DRAIN (MAC_LAT cycles): outputs idle; counter expires -> DONE.
//  DONE (1 cycle): dout_valid=1; wptr<=wptr+1 mod 2^DAW; -> IDLE.
//  Latency: stb seen at edge k -> dwr_en in cycle k+1, mac_en k+2..k+1+NTAPS,
//        dout_valid in cycle k+2+NTAPS+MAC_LAT (70 cycles at defaults).
//  sample_stb in WRITE/RUN/DRAIN: dropped, overrun=1.
//  sample_stb in DONE: pending=1, no overrun (back-to-back allowed).
//  cload=1 in WRITE/RUN/DRAIN: abort next edge -> IDLE; no dout_valid;
//        wptr unchanged; abort_err=1; mac_en deasserted same edge.
//  ovr_clr: clears overrun and abort_err; simultaneous set wins.
//  Address outputs hold last value outside RUN/WRITE; no X on any output.
//  Async reset mid-operation: immediately to reset values; pending sample lost.
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle -> all outputs 0 without clock edge.
//  2 Single stb, wptr=0, defaults -> dwr_en@1 addr 0; mac_en@2..66, crd 0..64,
//    drd 0,127,126..64; acc_clr only @2; dout_valid only @70; wptr=1.
//  3 130 samples spaced 256 cycles -> dwr_addr wraps 127->0; sample 129 drd
//    sequence starts 1,0,127; no overrun.
//  4 Second stb during RUN -> overrun=1, one dout_valid; ovr_clr -> overrun=0.
//  5 stb with cload=1 for 40 cycles -> no dwr_en until cload falls, WRITE on
//    next cycle; cload rise at tap 10 -> mac_en low next cycle, abort_err=1,
//    no dout_valid, next sample reuses same dwr_addr.
//  6 stb during DONE -> next WRITE one cycle after DONE->IDLE, overrun stays 0.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// Per-sample tap sequencer for the FP16 FIR MAC datapath. It writes each new
// sample into the circular data memory, walks every coefficient/data address
// pair, waits out the MAC pipeline and then flags the result. While the
// coefficient loader owns the memory, the sequencer holds one sample or aborts.
module fir_tap_sequencer #(
  parameter int NTAPS   = 65,
  parameter int CAW     = 7,
  parameter int DAW     = 7,
  parameter int MAC_LAT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sample_stb,
  input  logic           cload,
  input  logic           ovr_clr,
  output logic           dwr_en,
  output logic [DAW-1:0] dwr_addr,
  output logic [CAW-1:0] crd_addr,
  output logic [DAW-1:0] drd_addr,
  output logic           mac_en,
  output logic           acc_clr,
  output logic           dout_valid,
  output logic           busy,
  output logic           overrun,
  output logic           abort_err
);

  localparam int             DCW      = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [CAW-1:0] TAP_LAST = CAW'(NTAPS - 1);
  localparam logic [DCW-1:0] DRN_LAST = DCW'(MAC_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [DAW-1:0] wptr_q;
  logic [CAW-1:0] tap_q;
  logic [DCW-1:0] dcnt_q;
  logic           pending_q;
  logic [DAW-1:0] wa_q, ra_q;   // last driven write / data-read address
  logic [CAW-1:0] ca_q;         // last driven coefficient address
  logic [DAW-1:0] rd_addr;
  logic           active;       // abortable states; strobes here are lost

  assign active  = (state_q == S_WRITE) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign rd_addr = wptr_q - DAW'(tap_q);
  assign busy    = (state_q != S_IDLE);

  // Addresses are live in their own state and hold the last value elsewhere.
  assign dwr_addr = (state_q == S_WRITE) ? wptr_q  : wa_q;
  assign crd_addr = (state_q == S_RUN)   ? tap_q   : ca_q;
  assign drd_addr = (state_q == S_RUN)   ? rd_addr : ra_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and strobe outputs; cload wins over progress in abortable states.
  always_comb begin
    state_d    = state_q;
    dwr_en     = 1'b0;
    mac_en     = 1'b0;
    acc_clr    = 1'b0;
    dout_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((sample_stb || pending_q) && !cload) state_d = S_WRITE;
      end
      S_WRITE: begin
        dwr_en  = 1'b1;
        state_d = cload ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        mac_en  = 1'b1;
        acc_clr = (tap_q == '0);
        if (cload)                  state_d = S_IDLE;
        else if (tap_q == TAP_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cload)                   state_d = S_IDLE;
        else if (dcnt_q == DRN_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        dout_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tap / drain counters, write pointer and held address copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      tap_q  <= '0;
      dcnt_q <= '0;
      wa_q   <= '0;
      ca_q   <= '0;
      ra_q   <= '0;
    end else begin
      case (state_q)
        S_WRITE: begin
          tap_q <= '0;
          wa_q  <= wptr_q;
        end
        S_RUN: begin
          tap_q  <= tap_q + CAW'(1);
          ca_q   <= tap_q;
          ra_q   <= rd_addr;
          dcnt_q <= '0;
        end
        S_DRAIN: dcnt_q <= dcnt_q + DCW'(1);
        S_DONE:  wptr_q <= wptr_q + DAW'(1);
        default: ;
      endcase
    end
  end

  // One held sample, plus sticky overrun / abort flags (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      overrun   <= 1'b0;
      abort_err <= 1'b0;
    end else begin
      if (sample_stb && (active || ((state_q == S_IDLE) && pending_q))) overrun <= 1'b1;
      else if (ovr_clr)                                                  overrun <= 1'b0;

      if (cload && active) abort_err <= 1'b1;
      else if (ovr_clr)    abort_err <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (!cload && (sample_stb || pending_q)) pending_q <= 1'b0;
          else if (sample_stb)                     pending_q <= 1'b1;
        end
        S_DONE:  if (sample_stb) pending_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: strobe plans are turned into expected per-cycle
// traces from the latency rules, then compared against the DUT every cycle.
module tb_fir_tap_sequencer;

  localparam int N    = 65;
  localparam int L    = 3;
  localparam int MAXC = 33600;

  logic       clk, rst_n, sample_stb, cload, ovr_clr;
  logic       dwr_en, mac_en, acc_clr, dout_valid, busy, overrun, abort_err;
  logic [6:0] dwr_addr, crd_addr, drd_addr;
  logic [27:0] outs;

  int checks = 0;
  int errors = 0;
  int m_wptr = 0;

  bit         plan   [MAXC];
  bit         e_dwr  [MAXC];
  bit         e_mac  [MAXC];
  bit         e_clr  [MAXC];
  bit         e_dv   [MAXC];
  bit         e_busy [MAXC];
  logic [6:0] e_wa   [MAXC];
  logic [6:0] e_crd  [MAXC];
  logic [6:0] e_drd  [MAXC];

  fir_tap_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_stb (sample_stb),
    .cload      (cload),
    .ovr_clr    (ovr_clr),
    .dwr_en     (dwr_en),
    .dwr_addr   (dwr_addr),
    .crd_addr   (crd_addr),
    .drd_addr   (drd_addr),
    .mac_en     (mac_en),
    .acc_clr    (acc_clr),
    .dout_valid (dout_valid),
    .busy       (busy),
    .overrun    (overrun),
    .abort_err  (abort_err)
  );

  assign outs = {dwr_en, dwr_addr, crd_addr, drd_addr, mac_en, acc_clr,
                 dout_valid, busy, overrun, abort_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < MAXC; i++) plan[i] = 1'b0;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    m_wptr = 0;
  endtask

  // Predict the trace of a strobe-only plan (cload low) and check it cycle by
  // cycle. A strobe is accepted when the sequencer is idle, held when it lands
  // on the result cycle, and dropped (overrun) otherwise.
  task automatic run_plan(input int plen, input string tag);
    int busy_end = -1;
    int pend_c   = -1;
    int n;
    bit ovr      = 1'b0;
    bit launch;
    bit st;
    logic [4:0] act, expv;
    for (int i = 0; i < MAXC; i++) begin
      e_dwr[i] = 0; e_mac[i] = 0; e_clr[i] = 0; e_dv[i] = 0; e_busy[i] = 0;
      e_wa[i] = '0; e_crd[i] = '0; e_drd[i] = '0;
    end
    for (int c = 0; c < plen + 2; c++) begin
      launch = 1'b0;
      st = (c < MAXC) ? plan[c] : 1'b0;
      if (c == pend_c) begin
        launch = 1'b1;
        if (st) ovr = 1'b1;
      end else if (st) begin
        if (c > busy_end)       launch = 1'b1;
        else if (c == busy_end) pend_c = c + 1;
        else                    ovr = 1'b1;
      end
      if (launch) begin
        e_dwr[c+1] = 1'b1;
        e_wa[c+1]  = 7'(m_wptr);
        for (int t = 0; t < N; t++) begin
          e_mac[c+2+t] = 1'b1;
          e_crd[c+2+t] = 7'(t);
          e_drd[c+2+t] = 7'((m_wptr - t + 128) % 128);
        end
        e_clr[c+2]   = 1'b1;
        e_dv[c+2+N+L] = 1'b1;
        for (int d = c + 1; d <= c + 2 + N + L; d++) e_busy[d] = 1'b1;
        busy_end = c + 2 + N + L;
        m_wptr   = (m_wptr + 1) % 128;
      end
    end
    n = (busy_end + 2 > plen) ? busy_end + 2 : plen;
    for (int c = 0; c < n; c++) begin
      sample_stb = (c < plen) ? plan[c] : 1'b0;
      act  = {dwr_en, mac_en, acc_clr, dout_valid, busy};
      expv = {e_dwr[c], e_mac[c], e_clr[c], e_dv[c], e_busy[c]};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL %s ctl cyc %0d got dwr/mac/clr/dv/busy=%b exp %b", tag, c, act, expv);
      end
      if (e_dwr[c]) begin
        checks++;
        if (dwr_addr !== e_wa[c]) begin
          errors++;
          $display("FAIL %s dwr_addr cyc %0d got %0d exp %0d", tag, c, dwr_addr, e_wa[c]);
        end
      end
      if (e_mac[c]) begin
        checks++;
        if ({crd_addr, drd_addr} !== {e_crd[c], e_drd[c]}) begin
          errors++;
          $display("FAIL %s rd_addr cyc %0d got crd %0d drd %0d exp crd %0d drd %0d",
                   tag, c, crd_addr, drd_addr, e_crd[c], e_drd[c]);
        end
      end
      step();
    end
    sample_stb = 1'b0;
    checks++;
    if (overrun !== ovr) begin
      errors++;
      $display("FAIL %s overrun got %b exp %b", tag, overrun, ovr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; sample_stb = 1'b0; cload = 1'b0; ovr_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_por outputs got %h exp 0", outs);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    sample_stb = 1'b1;
    step();
    sample_stb = 1'b0;
    repeat (11) step();
    checks++;
    if ({mac_en, busy} !== 2'b11) begin
      errors++;
      $display("FAIL reset_prerun mac_en/busy got %b exp 11", {mac_en, busy});
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_midop outputs got %h exp 0", outs);
    end
    step();
    rst_n = 1'b1;
    // A held sample must not survive reset.
    cload = 1'b1; sample_stb = 1'b1;
    step();
    sample_stb = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; cload = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({dwr_en, busy} !== 2'b00) begin
        errors++;
        $display("FAIL reset_pending cyc %0d dwr_en/busy got %b exp 00", i, {dwr_en, busy});
      end
      step();
    end
    m_wptr = 0;
  endtask

  task automatic test_single();
    clear_plan();
    plan[0] = 1'b1;
    run_plan(1, "single");
    checks++;
    if ({dwr_addr, crd_addr, drd_addr} !== {7'd0, 7'd64, 7'd64}) begin
      errors++;
      $display("FAIL single_hold got dwr %0d crd %0d drd %0d exp 0 64 64",
               dwr_addr, crd_addr, drd_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    clear_plan();
    for (int i = 0; i < 130; i++) plan[i*256] = 1'b1;
    run_plan(130 * 256, "wrap");
  endtask

  task automatic test_overrun();
    bit seen;
    clear_plan();
    plan[0]  = 1'b1;
    plan[30] = 1'b1;
    run_plan(31, "overrun");
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got %b exp 0", overrun);
    end
    // A drop coinciding with ovr_clr must keep the flag set.
    sample_stb = 1'b1;
    step();
    sample_stb = 1'b0;
    repeat (5) step();
    sample_stb = 1'b1; ovr_clr = 1'b1;
    step();
    sample_stb = 1'b0; ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_wins got %b exp 1", overrun);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (dout_valid === 1'b1) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ovr_dout_timeout got none exp dout_valid within 100 cycles");
    end
    step();
    m_wptr = (m_wptr + 1) % 128;
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear2 got %b exp 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    clear_plan();
    plan[0]      = 1'b1;
    plan[2+N+L]  = 1'b1;   // lands on the result cycle
    run_plan(3 + N + L, "b2b");
  endtask

  task automatic test_cload();
    logic [6:0] wa;
    wa = 7'(m_wptr);
    cload = 1'b1; sample_stb = 1'b1;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if ({dwr_en, busy} !== 2'b00) begin
        errors++;
        $display("FAIL cload_hold cyc %0d dwr_en/busy got %b exp 00", c, {dwr_en, busy});
      end
      step();
      sample_stb = 1'b0;
    end
    cload = 1'b0;
    step();
    checks++;
    if ({dwr_en, dwr_addr} !== {1'b1, wa}) begin
      errors++;
      $display("FAIL cload_write got en %b addr %0d exp en 1 addr %0d", dwr_en, dwr_addr, wa);
    end
    step();
    for (int t = 0; t < 10; t++) begin
      checks++;
      if ({mac_en, crd_addr} !== {1'b1, 7'(t)}) begin
        errors++;
        $display("FAIL cload_run tap %0d got mac %b crd %0d exp mac 1 crd %0d", t, mac_en, crd_addr, t);
      end
      step();
    end
    cload = 1'b1;
    checks++;
    if ({mac_en, crd_addr, drd_addr} !== {1'b1, 7'd10, 7'((int'(wa) - 10 + 128) % 128)}) begin
      errors++;
      $display("FAIL cload_tap10 got mac %b crd %0d drd %0d exp mac 1 crd 10 drd %0d",
               mac_en, crd_addr, drd_addr, (int'(wa) - 10 + 128) % 128);
    end
    step();
    checks++;
    if ({mac_en, busy, abort_err, overrun} !== 4'b0010) begin
      errors++;
      $display("FAIL cload_abort mac/busy/abort/ovr got %b exp 0010",
               {mac_en, busy, abort_err, overrun});
    end
    cload = 1'b0;
    for (int c = 0; c < 80; c++) begin
      checks++;
      if ({dout_valid, mac_en} !== 2'b00) begin
        errors++;
        $display("FAIL cload_nodout cyc %0d dv/mac got %b exp 00", c, {dout_valid, mac_en});
      end
      step();
    end
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    checks++;
    if (abort_err !== 1'b0) begin
      errors++;
      $display("FAIL cload_abort_clr got %b exp 0", abort_err);
    end
    clear_plan();
    plan[0] = 1'b1;
    run_plan(1, "after_abort");   // same write address as the aborted sample
  endtask

  task automatic test_random();
    int c, gap, r;
    for (int round = 0; round < 4; round++) begin
      clear_plan();
      c = 0;
      for (int k = 0; k < 8; k++) begin
        plan[c] = 1'b1;
        r = $urandom_range(0, 9);
        if (r < 3)       gap = $urandom_range(1, 69);
        else if (r < 5)  gap = 70;
        else if (r == 5) gap = 71;
        else             gap = $urandom_range(72, 160);
        c += gap;
      end
      run_plan(c, "rand");
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
        errors++;
        $display("FAIL rand_ovr_clr round %0d got %b exp 0", round, overrun);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_overrun();
    test_back_to_back();
    test_cload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
